// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the slide-switch debouncer.
// Bit-level FSM encoding plus the default width and 10 ms @ 100 MHz cycle count.
package sw_pkg;

  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

  localparam int SW_WIDTH              = 4;
  localparam int DB_CYCLES_100MHZ_10MS = 1000000;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, stability FSM/counter and rise/fall strobes.
// With SW_DEBOUNCE_BYPASS_EN defined the FSM and counter are removed.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_100MHZ_10MS
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw,
  output logic      clean,
  output logic      clean_nxt,
  output logic      rise,
  output logic      fall,
  output db_state_t state_dbg
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef SW_DEBOUNCE_BYPASS_EN

  assign clean_nxt = s;
  assign state_dbg = DB_STABLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      clean <= clean_nxt;
      rise  <= clean_nxt & ~clean;
      fall  <= ~clean_nxt & clean;
    end
  end

`else

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t     state;
  logic [CW-1:0] cnt;

  // The new level is accepted on the edge where the count has already reached its maximum.
  assign clean_nxt = (state == DB_COUNTING && s != clean && cnt == CNT_MAX) ? s : clean;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DB_STABLE;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      case (state)
        DB_STABLE: begin
          if (s != clean) begin
            state <= DB_COUNTING;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        DB_COUNTING: begin
          if (s == clean || cnt == CNT_MAX) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_STABLE;
          cnt   <= '0;
        end
      endcase
      clean <= clean_nxt;
      rise  <= clean_nxt & ~clean;
      fall  <= ~clean_nxt & clean;
    end
  end

`endif

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch input conditioning: per-bit synchronise + debounce, plus any-on flag.
// Define SW_DEBOUNCE_BYPASS_EN to pass synchronised levels straight through.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES_100MHZ_10MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any
);

  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] counting_dbg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    db_state_t bit_state;

    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (sw_raw[i]),
      .clean    (sw_clean[i]),
      .clean_nxt(clean_nxt[i]),
      .rise     (sw_rise[i]),
      .fall     (sw_fall[i]),
      .state_dbg(bit_state)
    );

    assign counting_dbg[i] = (bit_state == DB_COUNTING);
  end

  // Built from next-state levels so the flag moves on the same edge as sw_clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_any <= 1'b0;
    end else begin
      sw_any <= |clean_nxt;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) (sw_rise & sw_fall) == '0);

`ifdef SW_DEBOUNCE_BYPASS_EN
  assert property (@(posedge clk) counting_dbg == '0);
`else
  assert property (@(posedge clk) disable iff (!rst_n)
                   ((sw_rise | sw_fall) & ~$past(counting_dbg)) == '0);
`endif

endmodule
